// File: rtl/spi_puzzle_slave_pkg.sv
// rtl/spi_puzzle_slave_pkg.sv - shared constants and FSM encoding for the SPI puzzle slave
package spi_puzzle_slave_pkg;

  localparam int SPI_MODE = 0;
  localparam bit MSB_FIRST = 1'b1;
  localparam logic [7:0] EOT_BYTE_DEFAULT = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_BYTE_END
  } spi_state_e;

endpackage

// File: rtl/spi_puzzle_slave_if.sv
// rtl/spi_puzzle_slave_if.sv - SPI pad and RAM preload bus between master side and slave
interface spi_puzzle_slave_if #(
  parameter int AW = 15
);

  logic          sclk_pad;
  logic          mosi_pad;
  logic          ss_n_pad;
  logic          miso;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;

  modport master (
    output sclk_pad, mosi_pad, ss_n_pad, load_en, load_addr, load_data,
    input  miso
  );

  modport slave (
    input  sclk_pad, mosi_pad, ss_n_pad, load_en, load_addr, load_data,
    output miso
  );

endinterface

// File: rtl/spi_puzzle_slave_sync.sv
// rtl/spi_puzzle_slave_sync.sv - pad synchronizers with sclk and ss_n edge detection
module spi_puzzle_slave_sync #(
  parameter int SYNC_FLOPS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_pad,
  input  logic mosi_pad,
  input  logic ss_n_pad,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_rise,
  output logic ss_fall,
  output logic mosi
);

  logic [SYNC_FLOPS-1:0] sclk_sync;
  logic [SYNC_FLOPS-1:0] mosi_sync;
  logic [SYNC_FLOPS-1:0] ss_sync;
  logic                  sclk_d;
  logic                  ss_d;

  // ss_n chain resets high so leaving reset never looks like a select
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync[0] <= sclk_pad;
      mosi_sync[0] <= mosi_pad;
      ss_sync[0]   <= ss_n_pad;
      for (int i = 1; i < SYNC_FLOPS; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
        ss_sync[i]   <= ss_sync[i-1];
      end
      sclk_d <= sclk_sync[SYNC_FLOPS-1];
      ss_d   <= ss_sync[SYNC_FLOPS-1];
    end
  end

  assign sclk_rise = sclk_sync[SYNC_FLOPS-1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[SYNC_FLOPS-1] & sclk_d;
  assign ss_rise   = ss_sync[SYNC_FLOPS-1] & ~ss_d;
  assign ss_fall   = ~ss_sync[SYNC_FLOPS-1] & ss_d;
  assign mosi      = mosi_sync[SYNC_FLOPS-1];

endmodule

// File: rtl/spi_puzzle_slave.sv
// rtl/spi_puzzle_slave.sv - SPI mode-0 slave streaming a preloaded puzzle, then EOT bytes
module spi_puzzle_slave
  import spi_puzzle_slave_pkg::*;
#(
  parameter int         DEPTH      = 32768,
  parameter logic [7:0] EOT_BYTE   = EOT_BYTE_DEFAULT,
  parameter int         SYNC_FLOPS = 2,
  localparam int        AW         = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  spi_puzzle_slave_if.slave   bus,
  input  logic [AW:0]         puzzle_len,
  output logic [7:0]          rx_byte,
  output logic                rx_byte_valid,
  output logic [AW:0]         tx_count,
  output logic                puzzle_done
);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;

  spi_puzzle_slave_sync #(.SYNC_FLOPS(SYNC_FLOPS)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk_pad  (bus.sclk_pad),
    .mosi_pad  (bus.mosi_pad),
    .ss_n_pad  (bus.ss_n_pad),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_rise   (ss_rise),
    .ss_fall   (ss_fall),
    .mosi      (mosi_s)
  );

  spi_state_e    state, state_nx;
  logic [7:0]    ram [DEPTH];
  logic [7:0]    ram_q, shift_reg, rx_shift, next_byte;
  logic [3:0]    bit_cnt;
  logic [AW:0]   len_q, cnt_after;
  logic [AW-1:0] rd_addr;
  logic          miso_q;
  logic          abort, latch_len, load_byte, byte_done, rx_shift_en, tx_shift_en;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state != ST_IDLE && ss_rise) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (ss_fall) state_nx = ST_LOAD;
        ST_LOAD:     state_nx = ST_SHIFT;
        ST_SHIFT:    if (sclk_fall && bit_cnt == 4'd8) state_nx = ST_BYTE_END;
        ST_BYTE_END: state_nx = ST_SHIFT;
        default:     state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    abort       = 1'b0;
    latch_len   = 1'b0;
    load_byte   = 1'b0;
    byte_done   = 1'b0;
    rx_shift_en = 1'b0;
    tx_shift_en = 1'b0;
    if (state != ST_IDLE && ss_rise) begin
      abort = 1'b1;
    end else begin
      case (state)
        ST_IDLE:  latch_len = ss_fall;
        ST_LOAD:  load_byte = 1'b1;
        ST_SHIFT: begin
          rx_shift_en = sclk_rise;
          tx_shift_en = sclk_fall && bit_cnt != 4'd8;
        end
        ST_BYTE_END: begin
          load_byte = 1'b1;
          byte_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // While shifting, the RAM already looks one byte ahead so BYTE_END has it ready
  assign rd_addr   = (state == ST_SHIFT) ? tx_count[AW-1:0] + AW'(1) : tx_count[AW-1:0];
  assign cnt_after = (byte_done && tx_count < len_q) ? tx_count + (AW+1)'(1) : tx_count;
  assign next_byte = (cnt_after < len_q) ? ram_q : EOT_BYTE;
  assign bus.miso  = miso_q;

  always_ff @(posedge clk) begin
    if (bus.load_en) ram[bus.load_addr] <= bus.load_data;
    ram_q <= ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miso_q        <= 1'b0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      tx_count      <= '0;
      puzzle_done   <= 1'b0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      rx_shift      <= '0;
      len_q         <= '0;
    end else begin
      rx_byte_valid <= 1'b0;
      if (latch_len) len_q <= puzzle_len;
      if (abort) begin
        miso_q  <= 1'b0;
        bit_cnt <= '0;
      end
      if (load_byte) begin
        shift_reg   <= next_byte;
        miso_q      <= next_byte[7];
        bit_cnt     <= '0;
        puzzle_done <= (cnt_after >= len_q);
      end
      if (byte_done) begin
        rx_byte       <= rx_shift;
        rx_byte_valid <= 1'b1;
        tx_count      <= cnt_after;
      end
      if (rx_shift_en) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 4'd1;
      end
      if (tx_shift_en) begin
        shift_reg <= {shift_reg[6:0], 1'b0};
        miso_q    <= shift_reg[6];
      end
    end
  end

endmodule
